// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream controller and its skid buffer.
package fifo_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned READ_LATENCY       = 1;

    // Words committed to the buffer after this edge; 3 bits so occ + inflight - pop never wraps.
    function automatic logic [2:0] credit_sum(input logic [1:0] occ,
                                              input logic       inflight,
                                              input logic       pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// Two-entry output buffer: head is the registered stream word, tail absorbs one extra capture.
module fifo_skid_buffer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_data;
                else               tail_d = push_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Pop never happens on an empty buffer, so occ is 1 or 2 here.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data = head_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: issues read_en against buffer credit,
// captures words one cycle later and re-presents them on a valid/ready stream.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   fifo_empty,
    output logic                   read_en,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] words_read
);

    logic [1:0]             state_q, state_d;
    logic                   inflight_q, inflight_d;
    logic [COUNT_WIDTH-1:0] words_read_q, words_read_d;
    logic [1:0]             occ;
    logic [DATA_WIDTH-1:0]  head_data;
    logic                   pop;
    logic [2:0]             credit;

    assign pop       = out_valid && out_ready;
    assign credit    = credit_sum(occ, inflight_q, pop);
    assign read_en   = (state_q == ST_RUN) && !fifo_empty && (credit < 3'd2);
    assign out_valid = (occ != 2'd0);
    assign out_data  = head_data;
    assign busy      = (state_q != ST_IDLE);

    fifo_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .head_data (head_data),
        .occ       (occ)
    );

    always_comb begin
        state_d      = state_q;
        inflight_d   = read_en;
        words_read_d = words_read_q + {{(COUNT_WIDTH-1){1'b0}}, pop};
        unique case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)                               state_d = ST_RUN;
                else if (!inflight_q && (occ == 2'd0))    state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            inflight_q   <= 1'b0;
            words_read_q <= '0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            words_read_q <= words_read_d;
        end
    end

    assign words_read = words_read_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a behavioural 1-cycle-latency FIFO.
module tb_fifo_stream_reader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        out_ready = 1'b0;
    logic        fifo_empty;
    logic        read_en;
    logic [7:0]  fifo_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        busy;
    logic [15:0] words_read;

    logic        enable4 = 1'b0;
    logic        out_ready4 = 1'b1;
    logic        fifo_empty4;
    logic        read_en4;
    logic [7:0]  fifo_data4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic        busy4;
    logic [3:0]  words_read4;

    logic [7:0]  mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd4 = 0;
    logic        flush_req = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    fifo_stream_reader dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .read_en    (read_en),
        .fifo_data  (fifo_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .words_read (words_read)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable4),
        .fifo_empty (fifo_empty4),
        .read_en    (read_en4),
        .fifo_data  (fifo_data4),
        .out_valid  (out_valid4),
        .out_data   (out_data4),
        .out_ready  (out_ready4),
        .busy       (busy4),
        .words_read (words_read4)
    );

    // FIFO models: data appears one cycle after read_en.
    assign fifo_empty  = (rd_ptr == wr_ptr);
    assign fifo_empty4 = (rd4 >= 17);

    always @(posedge clock) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (read_en) begin
            fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
        if (read_en4) begin
            fifo_data4 <= 8'(rd4);
            rd4        <= rd4 + 1;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = first + 8'(i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic flush;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    task automatic test_reset;
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (read_en !== 1'b0) begin n_fail++; $display("FAIL reset_read_en: got %b expected 0", read_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (words_read !== 16'd0) begin n_fail++; $display("FAIL reset_words_read: got %0d expected 0", words_read); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
        n_checks++; if (out_data4 !== 8'h00) begin n_fail++; $display("FAIL reset_out_data4: got %h expected 00", out_data4); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_streaming;
        logic exp_re, exp_v;
        logic [15:0] exp_wr;
        load(8'h01, 8);
        tick();
        enable = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++; if (read_en !== 1'b0) begin n_fail++; $display("FAIL stream_idle_read_en: got %b expected 0", read_en); end
        for (int c = 1; c <= 12; c++) begin
            tick();
            #1;
            exp_re = (c <= 8);
            exp_v  = (c >= 3 && c <= 10);
            exp_wr = (c < 3) ? 16'd0 : ((c > 11) ? 16'd8 : 16'(c - 3));
            n_checks++; if (read_en !== exp_re) begin n_fail++; $display("FAIL stream_read_en c%0d: got %b expected %b", c, read_en, exp_re); end
            n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL stream_out_valid c%0d: got %b expected %b", c, out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (out_data !== 8'(c - 2)) begin n_fail++; $display("FAIL stream_out_data c%0d: got %h expected %h", c, out_data, 8'(c - 2)); end
            end
            n_checks++; if (words_read !== exp_wr) begin n_fail++; $display("FAIL stream_words_read c%0d: got %0d expected %0d", c, words_read, exp_wr); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stream_busy c%0d: got %b expected 1", c, busy); end
        end
        enable = 1'b0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_pressure;
        logic exp_re, exp_v;
        logic [7:0]  exp_d;
        logic [15:0] exp_wr;
        load(8'h01, 4);
        tick();
        enable = 1'b1;
        out_ready = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            out_ready = (c >= 7);
            #1;
            exp_re = (c == 1 || c == 2 || c == 7 || c == 8);
            exp_v  = (c >= 3 && c <= 10);
            exp_d  = (c <= 7) ? 8'h01 : 8'(c - 6);
            exp_wr = (c <= 7) ? 16'd8 : ((c >= 11) ? 16'd12 : 16'(c + 1));
            n_checks++; if (read_en !== exp_re) begin n_fail++; $display("FAIL bp_read_en c%0d: got %b expected %b", c, read_en, exp_re); end
            n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b expected %b", c, out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL bp_out_data c%0d: got %h expected %h", c, out_data, exp_d); end
            end
            n_checks++; if (words_read !== exp_wr) begin n_fail++; $display("FAIL bp_words_read c%0d: got %0d expected %0d", c, words_read, exp_wr); end
        end
        enable = 1'b0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_empty_boundary;
        load(8'hA5, 1);
        tick();
        enable = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            #1;
            n_checks++; if (read_en !== (c == 1)) begin n_fail++; $display("FAIL empty_read_en c%0d: got %b expected %b", c, read_en, (c == 1)); end
            n_checks++; if (out_valid !== (c == 3)) begin n_fail++; $display("FAIL empty_out_valid c%0d: got %b expected %b", c, out_valid, (c == 3)); end
            if (c == 3) begin
                n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL empty_out_data: got %h expected a5", out_data); end
            end
        end
        n_checks++; if (words_read !== 16'd13) begin n_fail++; $display("FAIL empty_words_read: got %0d expected 13", words_read); end
        enable = 1'b0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_drain;
        logic exp_re, exp_v;
        logic [7:0] exp_d;
        load(8'h11, 5);
        tick();
        enable = 1'b1;
        out_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 4) begin
                enable = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            exp_re = (c == 1 || c == 2 || c == 4);
            exp_v  = (c >= 3 && c <= 6);
            exp_d  = (c <= 4) ? 8'h11 : 8'(8'h0D + c);
            n_checks++; if (read_en !== exp_re) begin n_fail++; $display("FAIL drain_read_en c%0d: got %b expected %b", c, read_en, exp_re); end
            n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL drain_out_valid c%0d: got %b expected %b", c, out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL drain_out_data c%0d: got %h expected %h", c, out_data, exp_d); end
            end
            n_checks++; if (busy !== (c <= 7)) begin n_fail++; $display("FAIL drain_busy c%0d: got %b expected %b", c, busy, (c <= 7)); end
        end
        n_checks++; if (words_read !== 16'd16) begin n_fail++; $display("FAIL drain_words_read: got %0d expected 16", words_read); end
        flush();
    endtask

    task automatic test_counter_wrap;
        tick();
        enable4 = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            #1;
            if (c == 18) begin
                n_checks++; if (words_read4 !== 4'd15) begin n_fail++; $display("FAIL wrap_pre c%0d: got %0d expected 15", c, words_read4); end
            end
            if (c == 19) begin
                n_checks++; if (words_read4 !== 4'd0) begin n_fail++; $display("FAIL wrap_zero c%0d: got %0d expected 0", c, words_read4); end
            end
        end
        n_checks++; if (words_read4 !== 4'd1) begin n_fail++; $display("FAIL wrap_final: got %0d expected 1", words_read4); end
        n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL wrap_out_valid: got %b expected 0", out_valid4); end
        enable4 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_midop;
        load(8'h31, 4);
        tick();
        enable = 1'b1;
        out_ready = 1'b0;
        repeat (5) tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midop_pre_valid: got %b expected 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (read_en !== 1'b0) begin n_fail++; $display("FAIL midop_read_en: got %b expected 0", read_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_busy: got %b expected 0", busy); end
        n_checks++; if (words_read !== 16'd0) begin n_fail++; $display("FAIL midop_words_read: got %0d expected 0", words_read); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL midop_out_data: got %h expected 00", out_data); end
        enable = 1'b0;
        flush();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_post_valid: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_empty_boundary();
        test_drain();
        test_counter_wrap();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
